// File: rtl/coolgirl_cfg_sequencer_pkg.sv
// Shared definitions for the CoolGirl configuration sequencer: register offsets,
// sequencer state encodings and the live/shadow configuration record with its reset value.
package coolgirl_cfg_sequencer_pkg;

  localparam logic [2:0] RegBaseLo = 3'd0;
  localparam logic [2:0] RegBaseHi = 3'd1;
  localparam logic [2:0] RegPrg    = 3'd2;
  localparam logic [2:0] RegChr    = 3'd3;
  localparam logic [2:0] RegFlags  = 3'd4;
  localparam logic [2:0] RegMapper = 3'd5;
  localparam logic [2:0] RegCtrl   = 3'd6;
  localparam logic [2:0] RegRsvd   = 3'd7;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StApply  = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;
  localparam logic [1:0] StLocked = 2'd3;

  typedef struct packed {
    logic [12:0] cpu_base;
    logic [6:0]  prg_mask;
    logic        rom6000;
    logic [4:0]  chr_mask;
    logic [1:0]  sram_page;
    logic        sram_en;
    logic        prg_we;
    logic        chr_we;
    logic        four_scr;
    logic [1:0]  mirroring;
    logic [5:0]  mapper;
  } cfg_t;

  localparam int unsigned CfgW = $bits(cfg_t);

  // Power-on layout boots the 32 KiB menu with CHR RAM writable.
  localparam cfg_t CfgReset = '{
    cpu_base:  13'd0,
    prg_mask:  7'b1111110,
    rom6000:   1'b0,
    chr_mask:  5'b11111,
    sram_page: 2'd0,
    sram_en:   1'b0,
    prg_we:    1'b0,
    chr_we:    1'b1,
    four_scr:  1'b0,
    mirroring: 2'd0,
    mapper:    6'd0
  };

endpackage

// File: rtl/coolgirl_cfg_shadow.sv
// Shadow register bank: collects CPU writes to R0..R5 until the sequencer commits them.
module coolgirl_cfg_shadow
  import coolgirl_cfg_sequencer_pkg::*;
#(
  parameter int unsigned USE_FOUR_SCREEN = 1
) (
  input  logic            m2,
  input  logic            reset_n,
  input  logic            we,
  input  logic [2:0]      idx,
  input  logic [7:0]      data,
  output logic [CfgW-1:0] shadow
);

  cfg_t shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (we) begin
      case (idx)
        RegBaseLo: shadow_d.cpu_base[7:0]  = data;
        RegBaseHi: shadow_d.cpu_base[12:8] = data[4:0];
        RegPrg: begin
          shadow_d.prg_mask = data[6:0];
          shadow_d.rom6000  = data[7];
        end
        RegChr: begin
          shadow_d.chr_mask  = data[4:0];
          shadow_d.sram_page = data[6:5];
        end
        RegFlags: begin
          shadow_d.sram_en   = data[0];
          shadow_d.prg_we    = data[1];
          shadow_d.chr_we    = data[2];
          shadow_d.four_scr  = (USE_FOUR_SCREEN != 0) ? data[3] : 1'b0;
          shadow_d.mirroring = data[5:4];
        end
        RegMapper: shadow_d.mapper = data[5:0];
        default: ;
      endcase
    end
  end

  always_ff @(negedge m2) begin
    if (!reset_n) shadow_q <= CfgReset;
    else          shadow_q <= shadow_d;
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/coolgirl_cfg_sequencer.sv
// CPU-side configuration controller: decodes $5000-$5FFF writes, commits the shadow bank
// atomically into the live config, holds the mapper in reset afterwards and supports locking.
module coolgirl_cfg_sequencer
  import coolgirl_cfg_sequencer_pkg::*;
#(
  parameter int unsigned MAPPER_RST_CYCLES = 4,
  parameter int unsigned USE_FOUR_SCREEN   = 1
) (
  input  logic        m2,
  input  logic        reset_n,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic [12:0] cpu_base,
  output logic [6:0]  prg_mask,
  output logic [4:0]  chr_mask,
  output logic [1:0]  sram_page,
  output logic        map_rom_on_6000,
  output logic        sram_enabled,
  output logic        prg_write_enabled,
  output logic        chr_write_enabled,
  output logic        four_screen,
  output logic [1:0]  mirroring,
  output logic [5:0]  mapper,
  output logic        mapper_reset,
  output logic        cfg_locked,
  output logic        write_dropped
);

  localparam int unsigned   CntW    = $clog2(MAPPER_RST_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(MAPPER_RST_CYCLES - 1);

  logic            reg_wr;
  logic [2:0]      reg_idx;
  logic            shadow_we;
  logic [CfgW-1:0] shadow_flat;
  cfg_t            shadow;
  logic            unused_addr;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_pend_q, lock_pend_d;
  logic            dropped_q, dropped_d;
  logic            rst_hold_q;
  cfg_t            live_q, live_d;

  assign reg_wr      = romsel & ~cpu_rw_in & (cpu_addr_in[14:12] == 3'b101);
  assign reg_idx     = cpu_addr_in[2:0];
  assign unused_addr = ^cpu_addr_in[11:3];
  assign shadow_we   = reg_wr & (state_q == StIdle);
  assign shadow      = cfg_t'(shadow_flat);

  coolgirl_cfg_shadow #(
    .USE_FOUR_SCREEN(USE_FOUR_SCREEN)
  ) u_shadow (
    .m2     (m2),
    .reset_n(reset_n),
    .we     (shadow_we),
    .idx    (reg_idx),
    .data   (cpu_data_in),
    .shadow (shadow_flat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_pend_d = lock_pend_q;
    live_d      = live_q;
    dropped_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Live config is loaded on the commit edge itself so it lines up with mapper_reset.
        if (reg_wr && reg_idx == RegCtrl) begin
          if (cpu_data_in[0]) begin
            live_d      = shadow;
            state_d     = StApply;
            cnt_d       = CntLoad;
            lock_pend_d = cpu_data_in[7];
          end else if (cpu_data_in[7]) begin
            state_d = StLocked;
          end
        end
      end
      StApply, StHold: begin
        dropped_d = reg_wr & (reg_idx != RegRsvd);
        if (cnt_q == '0) begin
          state_d     = lock_pend_q ? StLocked : StIdle;
          lock_pend_d = 1'b0;
        end else begin
          state_d = StHold;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: dropped_d = reg_wr & (reg_idx != RegRsvd);
    endcase
  end

  always_ff @(negedge m2) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lock_pend_q <= 1'b0;
      dropped_q   <= 1'b0;
      rst_hold_q  <= 1'b1;
      live_q      <= CfgReset;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_pend_q <= lock_pend_d;
      dropped_q   <= dropped_d;
      rst_hold_q  <= 1'b0;
      live_q      <= live_d;
    end
  end

  assign cpu_base          = live_q.cpu_base;
  assign prg_mask          = live_q.prg_mask;
  assign chr_mask          = live_q.chr_mask;
  assign sram_page         = live_q.sram_page;
  assign map_rom_on_6000   = live_q.rom6000;
  assign sram_enabled      = live_q.sram_en;
  assign prg_write_enabled = live_q.prg_we;
  assign chr_write_enabled = live_q.chr_we;
  assign four_screen       = (USE_FOUR_SCREEN != 0) & live_q.four_scr;
  assign mirroring         = live_q.mirroring;
  assign mapper            = live_q.mapper;
  assign mapper_reset      = ~reset_n | rst_hold_q | (state_q == StApply) | (state_q == StHold);
  assign cfg_locked        = (state_q == StLocked);
  assign write_dropped     = dropped_q;

endmodule

// File: tb/tb_coolgirl_cfg_sequencer.sv
// Scenario bench for the configuration sequencer; expected live configs are queued at commit time.
module tb_coolgirl_cfg_sequencer;

  logic        m2 = 1'b1;
  logic        reset_n, romsel, cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic [12:0] cpu_base;
  logic [6:0]  prg_mask;
  logic [4:0]  chr_mask;
  logic [1:0]  sram_page, mirroring;
  logic        map_rom_on_6000, sram_enabled, prg_write_enabled, chr_write_enabled, four_screen;
  logic [5:0]  mapper;
  logic        mapper_reset, cfg_locked, write_dropped;
  logic [39:0] live_vec;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  sh [0:5];
  logic [39:0] exp_q [$];
  bit          drop_q [$];
  logic [39:0] exp_v;
  bit          exp_d;

  coolgirl_cfg_sequencer dut (
    .m2(m2), .reset_n(reset_n), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_base(cpu_base),
    .prg_mask(prg_mask), .chr_mask(chr_mask), .sram_page(sram_page),
    .map_rom_on_6000(map_rom_on_6000), .sram_enabled(sram_enabled),
    .prg_write_enabled(prg_write_enabled), .chr_write_enabled(chr_write_enabled),
    .four_screen(four_screen), .mirroring(mirroring), .mapper(mapper),
    .mapper_reset(mapper_reset), .cfg_locked(cfg_locked), .write_dropped(write_dropped)
  );

  always #5 m2 = ~m2;

  assign live_vec = {cpu_base, prg_mask, chr_mask, sram_page, map_rom_on_6000, sram_enabled,
                     prg_write_enabled, chr_write_enabled, four_screen, mirroring, mapper};

  function automatic logic [39:0] exp_from(input logic [7:0] r0, r1, r2, r3, r4, r5);
    return {r1[4:0], r0, r2[6:0], r3[4:0], r3[6:5], r2[7], r4[0], r4[1], r4[2], r4[3],
            r4[5:4], r5[5:0]};
  endfunction

  function automatic logic [39:0] exp_model();
    return exp_from(sh[0], sh[1], sh[2], sh[3], sh[4], sh[5]);
  endfunction

  task automatic reset_model();
    sh[0] = 8'h00; sh[1] = 8'h00; sh[2] = 8'h7E;
    sh[3] = 8'h1F; sh[4] = 8'h04; sh[5] = 8'h00;
  endtask

  task automatic step();
    @(negedge m2);
    #1;
  endtask

  task automatic do_access(input logic rs, input logic rw, input logic [14:0] a,
                           input logic [7:0] d);
    romsel = rs; cpu_rw_in = rw; cpu_addr_in = a; cpu_data_in = d;
    step();
    romsel = 1'b1; cpu_rw_in = 1'b1; cpu_addr_in = 15'h0; cpu_data_in = 8'h00;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [7:0] d);
    do_access(1'b1, 1'b0, a, d);
  endtask

  task automatic hw_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    reset_model();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (mapper_reset !== 1'b1) begin
      n_bad++; $display("FAIL rst_mapper_reset: got %b want 1", mapper_reset);
    end
    n_cmp++;
    if (live_vec !== exp_model()) begin
      n_bad++; $display("FAIL rst_live: got %h want %h", live_vec, exp_model());
    end
    n_cmp++;
    if ({cfg_locked, write_dropped} !== 2'b00) begin
      n_bad++; $display("FAIL rst_flags: got %b want 00", {cfg_locked, write_dropped});
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (mapper_reset !== 1'b0) begin
      n_bad++; $display("FAIL rst_release: got %b want 0", mapper_reset);
    end
  endtask

  task automatic test_commit();
    int hi;
    do_write(15'h5000, 8'hA5); sh[0] = 8'hA5;
    do_write(15'h5001, 8'h03); sh[1] = 8'h03;
    n_cmp++;
    if (cpu_base !== 13'h0000) begin
      n_bad++; $display("FAIL precommit_base: got %h want 0000", cpu_base);
    end
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h01);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v) begin
      n_bad++; $display("FAIL commit_live: got %h want %h", live_vec, exp_v);
    end
    n_cmp++;
    if (cpu_base !== 13'h03A5) begin
      n_bad++; $display("FAIL commit_base: got %h want 03a5", cpu_base);
    end
    hi = mapper_reset ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mapper_reset) hi++;
    end
    n_cmp++;
    if (hi != 4) begin
      n_bad++; $display("FAIL commit_rst_len: got %0d edges want 4", hi);
    end
  endtask

  task automatic test_no_commit();
    do_write(15'h5005, 8'h04); sh[5] = 8'h04;
    n_cmp++;
    if (mapper !== 6'd0) begin
      n_bad++; $display("FAIL nocommit_mapper: got %0d want 0", mapper);
    end
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h01);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v || mapper !== 6'd4) begin
      n_bad++; $display("FAIL mapper_commit: got %h want %h", live_vec, exp_v);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    hw_reset();
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h01);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v) begin
      n_bad++; $display("FAIL b2b_commit: got %h want %h", live_vec, exp_v);
    end
    step();
    drop_q.push_back(1'b1);
    do_write(15'h5000, 8'hFF);
    exp_d = drop_q.pop_front();
    n_cmp++;
    if (write_dropped !== exp_d) begin
      n_bad++; $display("FAIL hold_drop: got %b want %b", write_dropped, exp_d);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (write_dropped) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("FAIL drop_pulse_len: got %0d extra want 0", pulses);
    end
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h01);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v || cpu_base[7:0] !== 8'h00) begin
      n_bad++; $display("FAIL hold_shadow_kept: got %h want %h", live_vec, exp_v);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_lock();
    int k;
    do_write(15'h5002, 8'h3C); sh[2] = 8'h3C;
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h81);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v || cfg_locked !== 1'b0) begin
      n_bad++; $display("FAIL lock_commit: got %h/%b want %h/0", live_vec, cfg_locked, exp_v);
    end
    k = 0;
    while (!cfg_locked && k < 10) begin
      step();
      k++;
    end
    n_cmp++;
    if (k != 4) begin
      n_bad++; $display("FAIL lock_entry: got %0d edges want 4", k);
    end
    drop_q.push_back(1'b1);
    do_write(15'h5002, 8'h00);
    exp_d = drop_q.pop_front();
    n_cmp++;
    if (write_dropped !== exp_d || prg_mask !== sh[2][6:0]) begin
      n_bad++; $display("FAIL locked_drop: got %b/%h want %b/%h", write_dropped, prg_mask,
                        exp_d, sh[2][6:0]);
    end
    drop_q.push_back(1'b0);
    do_write(15'h5007, 8'h55);
    exp_d = drop_q.pop_front();
    n_cmp++;
    if (write_dropped !== exp_d) begin
      n_bad++; $display("FAIL r7_no_drop: got %b want %b", write_dropped, exp_d);
    end
    do_write(15'h5006, 8'h01);
    n_cmp++;
    if ({write_dropped, mapper_reset, cfg_locked} !== 3'b101) begin
      n_bad++; $display("FAIL locked_commit: got %b want 101",
                        {write_dropped, mapper_reset, cfg_locked});
    end
  endtask

  task automatic test_mid_hold_reset();
    hw_reset();
    do_write(15'h5004, 8'h0F); sh[4] = 8'h0F;
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h01);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v) begin
      n_bad++; $display("FAIL flags_commit: got %h want %h", live_vec, exp_v);
    end
    step();
    reset_n = 1'b0;
    step();
    reset_model();
    n_cmp++;
    if (live_vec !== exp_model() || cfg_locked !== 1'b0 || mapper_reset !== 1'b1) begin
      n_bad++; $display("FAIL midhold_reset: got %h/%b/%b want %h/0/1", live_vec, cfg_locked,
                        mapper_reset, exp_model());
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (mapper_reset !== 1'b0) begin
      n_bad++; $display("FAIL midhold_idle: got %b want 0", mapper_reset);
    end
    do_write(15'h4005, 8'h3F);
    do_write(15'h6005, 8'h3F);
    do_access(1'b1, 1'b1, 15'h5005, 8'h3F);
    do_access(1'b0, 1'b0, 15'h5005, 8'h3F);
    do_access(1'b0, 1'b0, 15'h5006, 8'h01);
    n_cmp++;
    if (mapper_reset !== 1'b0) begin
      n_bad++; $display("FAIL romsel_commit: got %b want 0", mapper_reset);
    end
    exp_q.push_back(exp_model());
    do_write(15'h5006, 8'h01);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (live_vec !== exp_v) begin
      n_bad++; $display("FAIL undecoded_writes: got %h want %h", live_vec, exp_v);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; romsel = 1'b1; cpu_rw_in = 1'b1;
    cpu_addr_in = 15'h0; cpu_data_in = 8'h00;
    reset_model();
    test_reset();
    test_commit();
    test_no_commit();
    test_back_to_back();
    test_lock();
    test_mid_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
